// File: rtl/dt_stats.sv
// Distance-transform statistics: one pass over the 128x128 result memory
// producing max value/location, nonzero area and above-threshold count.
module dt_stats (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  thr,
   output logic        res_rd,
   output logic [13:0] res_addr,
   input  logic [7:0]  res_di,
   output logic        busy,
   output logic        done,
   output logic [7:0]  max_val,
   output logic [13:0] max_addr,
   output logic [14:0] area,
   output logic [14:0] thr_cnt
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

   localparam logic [13:0] LAST_ADDR = 14'd16383;

   state_t      r_state;
   logic        r_rd;
   logic        r_vld;
   logic        r_busy;
   logic        r_done;
   logic [13:0] r_addr;
   logic [13:0] r_paddr;
   logic [7:0]  r_thr;
   logic [7:0]  r_max;
   logic [13:0] r_maxaddr;
   logic [14:0] r_area;
   logic [14:0] r_thrcnt;
   logic [7:0]  r_omax;
   logic [13:0] r_omaxaddr;
   logic [14:0] r_oarea;
   logic [14:0] r_othr;

   logic [7:0]  w_max;
   logic [13:0] w_maxaddr;
   logic [14:0] w_area;
   logic [14:0] w_thrcnt;

   // Datum on res_di belongs to the address issued one cycle earlier (r_paddr)
   always_comb begin
      w_max     = r_max;
      w_maxaddr = r_maxaddr;
      w_area    = r_area;
      w_thrcnt  = r_thrcnt;
      if (r_vld) begin
         if (res_di > r_max) begin
            w_max     = res_di;
            w_maxaddr = r_paddr;
         end
         if (res_di != 8'd0)
            w_area = r_area + 15'd1;
         if (res_di >= r_thr)
            w_thrcnt = r_thrcnt + 15'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rd       <= 1'b0;
         r_vld      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_addr     <= '0;
         r_paddr    <= '0;
         r_thr      <= '0;
         r_max      <= '0;
         r_maxaddr  <= '0;
         r_area     <= '0;
         r_thrcnt   <= '0;
         r_omax     <= '0;
         r_omaxaddr <= '0;
         r_oarea    <= '0;
         r_othr     <= '0;
      end else begin
         r_vld     <= r_rd;
         r_paddr   <= r_addr;
         r_max     <= w_max;
         r_maxaddr <= w_maxaddr;
         r_area    <= w_area;
         r_thrcnt  <= w_thrcnt;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state   <= SCAN;
                  r_rd      <= 1'b1;
                  r_busy    <= 1'b1;
                  r_addr    <= '0;
                  r_thr     <= thr;
                  r_max     <= '0;
                  r_maxaddr <= '0;
                  r_area    <= '0;
                  r_thrcnt  <= '0;
               end
            end
            SCAN: begin
               if (r_addr == LAST_ADDR) begin
                  r_state <= DRAIN;
                  r_rd    <= 1'b0;
               end else begin
                  r_addr <= r_addr + 14'd1;
               end
            end
            DRAIN: begin
               r_state    <= FIN;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_omax     <= w_max;
               r_omaxaddr <= w_maxaddr;
               r_oarea    <= w_area;
               r_othr     <= w_thrcnt;
            end
            FIN: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign res_rd   = r_rd;
   assign res_addr = r_addr;
   assign busy     = r_busy;
   assign done     = r_done;
   assign max_val  = r_omax;
   assign max_addr = r_omaxaddr;
   assign area     = r_oarea;
   assign thr_cnt  = r_othr;

endmodule

// File: tb/tb_dt_stats.sv
// Bench for dt_stats: directed image table, reset abort, and a random image
// checked against a plain-arithmetic reference with stray start pulses.
module tb_dt_stats;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  thr;
   logic        res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di;
   logic        busy;
   logic        done;
   logic [7:0]  max_val;
   logic [13:0] max_addr;
   logic [14:0] area;
   logic [14:0] thr_cnt;

   logic [7:0] mem [0:16383];

   int checks = 0;
   int failures = 0;

   logic [7:0]  p_max;
   logic [13:0] p_addr;
   logic [14:0] p_area;
   logic [14:0] p_thr;

   typedef struct {
      int          pat;
      logic [7:0]  thr;
      logic [7:0]  emax;
      logic [13:0] eaddr;
      logic [14:0] earea;
      logic [14:0] ethr;
   } vec_t;

   vec_t vecs [3];

   dt_stats dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .thr      (thr),
      .res_rd   (res_rd),
      .res_addr (res_addr),
      .res_di   (res_di),
      .busy     (busy),
      .done     (done),
      .max_val  (max_val),
      .max_addr (max_addr),
      .area     (area),
      .thr_cnt  (thr_cnt)
   );

   always #5 clk = ~clk;

   // Result memory: one-cycle read latency
   always @(posedge clk)
      if (res_rd) res_di <= mem[res_addr];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic fill(input int pat);
      for (int a = 0; a < 16384; a++) begin
         case (pat)
            0: mem[a] = 8'd0;
            1: mem[a] = (a == 200) ? 8'd5 :
                        (a == 9000 || a == 12000) ? 8'd7 : 8'd0;
            2: mem[a] = (a == 16383) ? 8'd255 : 8'd1;
            default: begin
               case ($urandom_range(0, 3))
                  0: mem[a] = 8'd0;
                  1: mem[a] = 8'd255;
                  default: mem[a] = 8'($urandom_range(0, 255));
               endcase
            end
         endcase
      end
   endtask

   task automatic check_outs(input string tag, input logic [7:0] em,
                             input logic [13:0] ea, input logic [14:0] ar,
                             input logic [14:0] et);
      chk({tag, "_max_val"}, max_val, em);
      chk({tag, "_max_addr"}, max_addr, ea);
      chk({tag, "_area"}, area, ar);
      chk({tag, "_thr_cnt"}, thr_cnt, et);
   endtask

   // Full scan from IDLE; cycle n counts from the start-sampling edge
   task automatic run_scan(input string tag, input logic [7:0] t,
                           input bit inject, input logic [7:0] em,
                           input logic [13:0] ea, input logic [14:0] ar,
                           input logic [14:0] et);
      int sweep_err = 0;
      int hold_err = 0;
      int busy_n = 0;
      int done_n = 0;
      int done_at = -1;
      @(negedge clk);
      start = 1'b1;
      thr = t;
      @(posedge clk);
      for (int n = 1; n <= 16392; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            thr = ~t;
         end
         if (n <= 16384) begin
            if (!(res_rd && res_addr == 14'(n - 1))) sweep_err++;
         end else if (res_rd || res_addr != 14'd16383) begin
            sweep_err++;
         end
         if (n < 16386 && (max_val != p_max || max_addr != p_addr ||
                           area != p_area || thr_cnt != p_thr))
            hold_err++;
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = n;
         end
         if (n == 16386)
            check_outs({tag, "_fin"}, em, ea, ar, et);
         if (inject && (n == 100 || n == 16386)) start = 1'b1;
         if (inject && (n == 101 || n == 16387)) start = 1'b0;
      end
      chk({tag, "_addr_sweep_errs"}, sweep_err, 0);
      chk({tag, "_outputs_held_errs"}, hold_err, 0);
      chk({tag, "_busy_cycles"}, busy_n, 16385);
      chk({tag, "_done_cycle"}, done_at, 16386);
      chk({tag, "_done_count"}, done_n, 1);
      check_outs({tag, "_after"}, em, ea, ar, et);
      p_max = em;
      p_addr = ea;
      p_area = ar;
      p_thr = et;
   endtask

   initial begin
      logic [7:0]  rt;
      logic [7:0]  mm;
      logic [13:0] ma;
      int          ar;
      int          tc;
      int          n;
      int          bad;

      vecs[0] = '{pat: 0, thr: 8'd1, emax: 8'd0, eaddr: 14'd0,
                  earea: 15'd0, ethr: 15'd0};
      vecs[1] = '{pat: 1, thr: 8'd6, emax: 8'd7, eaddr: 14'd9000,
                  earea: 15'd3, ethr: 15'd2};
      vecs[2] = '{pat: 2, thr: 8'd0, emax: 8'd255, eaddr: 14'd16383,
                  earea: 15'd16384, ethr: 15'd16384};

      reset = 1'b1;
      start = 1'b0;
      thr = 8'd0;
      res_di = 8'd0;
      repeat (3) @(posedge clk);
      // Start together with reset must lose
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rst_res_rd", res_rd, 0);
      chk("rst_res_addr", res_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      check_outs("rst", 8'd0, 14'd0, 15'd0, 15'd0);
      reset = 1'b0;
      p_max = 8'd0;
      p_addr = 14'd0;
      p_area = 15'd0;
      p_thr = 15'd0;

      for (int i = 0; i < 3; i++) begin
         fill(vecs[i].pat);
         run_scan($sformatf("vec%0d", i), vecs[i].thr, 1'b0, vecs[i].emax,
                  vecs[i].eaddr, vecs[i].earea, vecs[i].ethr);
      end

      // Abort mid-scan with reset at address 5000
      fill(1);
      @(negedge clk);
      start = 1'b1;
      thr = 8'd3;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start = 1'b0;
      end while (!(res_rd && res_addr == 14'd5000) && n < 6000);
      chk("abort_reach_5000_cycle", n, 5001);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_res_rd", res_rd, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      check_outs("abort", 8'd0, 14'd0, 15'd0, 15'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy || res_rd) bad++;
      end
      chk("abort_quiet_errs", bad, 0);
      p_max = 8'd0;
      p_addr = 14'd0;
      p_area = 15'd0;
      p_thr = 15'd0;

      // Random image against reference, with ignored start pulses
      fill(3);
      rt = 8'($urandom_range(1, 254));
      mm = 8'd0;
      ma = 14'd0;
      ar = 0;
      tc = 0;
      for (int a = 0; a < 16384; a++) begin
         if (mem[a] > mm) begin
            mm = mem[a];
            ma = 14'(a);
         end
         if (mem[a] != 0) ar++;
         if (mem[a] >= rt) tc++;
      end
      run_scan("rand", rt, 1'b1, mm, ma, 15'(ar), 15'(tc));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
